// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
// Holds the opcode encodings, the logic-unit function indices (op[2:0] when
// op[3] == 0) and the control FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic [2:0] {
    LF_AND    = 3'd0,
    LF_OR     = 3'd1,
    LF_XOR    = 3'd2,
    LF_NAND   = 3'd3,
    LF_NOR    = 3'd4,
    LF_XNOR   = 3'd5,
    LF_PASS_A = 3'd6,
    LF_PASS_B = 3'd7
  } logic_fn_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       latch a/b and begin (ignored while a multiply is running)
//   a, b        operands
//   done        high during the WIDTH-th step cycle
//   product     low WIDTH bits of a*b, valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = active && (cnt == CNT_W'(WIDTH - 1));
  // The final step's sum is handed out directly so the consumer can register
  // the product on the same edge that completes the last step.
  assign product  = acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the accumulator is reset too, so an abandoned
  // multiply leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start && !active) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshakes and an optional iterative
// multiplier. Logic, ADD and reserved ops complete on the accepting edge;
// MUL occupies the unit for WIDTH cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake
//   a, b                  operands; invert_a/invert_b select ~a/~b
//   cin                   adder carry-in
//   op                    opcode (see alu_pkg)
//   out_valid / out_ready result handshake
//   result, N, Z, C, V    registered result and flags
//   busy                  multiply in progress
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_a,
  input  logic             invert_b,
  input  logic             cin,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] a_eff, b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c;

  assign a_eff     = invert_a ? ~a : a;
  assign b_eff     = invert_b ? ~b : b;
  assign sum       = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign is_mul    = (MUL_EN != 0) && (op == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a_eff),
        .b       (b_eff),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Logic unit and adder; MUL and reserved opcodes produce zero here.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    if (!op[3]) begin
      case (logic_fn_e'(op[2:0]))
        LF_AND:    res_c = a_eff & b_eff;
        LF_OR:     res_c = a_eff | b_eff;
        LF_XOR:    res_c = a_eff ^ b_eff;
        LF_NAND:   res_c = ~(a_eff & b_eff);
        LF_NOR:    res_c = ~(a_eff | b_eff);
        LF_XNOR:   res_c = ~(a_eff ^ b_eff);
        LF_PASS_A: res_c = a_eff;
        LF_PASS_B: res_c = b_eff;
      endcase
    end else if (op == OP_ADD) begin
      res_c = sum[WIDTH-1:0];
      c_c   = sum[WIDTH];
      // Signed overflow: operands agree in sign but the sum does not.
      v_c   = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
              (sum[WIDTH-1] != a_eff[WIDTH-1]);
    end
  end

  // Control FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = (state_q == ST_MUL_BUSY);
    in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
    case (state_q)
      ST_IDLE:     if (mul_start) state_d = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done)  state_d = ST_IDLE;
    endcase
  end

  // Output register. A new accept and a multiply completion never coincide
  // because in_ready is low while the multiplier runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= res_c;
      N         <= res_c[WIDTH-1];
      Z         <= (res_c == '0);
      C         <= c_c;
      V         <= v_c;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_product;
      N         <= mul_product[WIDTH-1];
      Z         <= (mul_product == '0);
      C         <= 1'b0;
      V         <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=4).
REQ-002 SHALL have parameter MUL_EN, default 1, enables iterative multiply op.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 invert_a, invert_b  input  1  use ~a / ~b as effective operands (a', b').
REQ-010 cin  input  1  adder carry-in.
REQ-011 op  input  4  opcode (Function).
REQ-012 out_valid  output  1  result/flags valid.
REQ-013 out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-014 result  output  WIDTH  registered result.
REQ-015 N, Z, C, V  output  1 each  registered flags.
REQ-016 busy  output  1  multiply in progress.

Function
REQ-017 op 0xxx: logic on a', b', xxx = 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass a', 111 pass b'.
REQ-018 op 1000: ADD, result = (a' + b' + cin) mod 2^WIDTH.
REQ-019 op 1001 with MUL_EN=1: MUL, result = low WIDTH bits of a' * b' (unsigned).
REQ-020 Other opcodes (and 1001 with MUL_EN=0): result 0, Z=1, N=C=V=0.
REQ-021 N = result[WIDTH-1]; Z = (result == 0) for every op.
REQ-022 C = adder carry-out for ADD, else 0.
REQ-023 V = 1 for ADD only when a', b' share sign bit and result sign differs; else 0.
REQ-024 States: IDLE, MUL_BUSY; IDLE -> MUL_BUSY on accepted MUL; MUL_BUSY -> IDLE after exactly WIDTH cycles.
REQ-025 in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-026 Logic/ADD/reserved: result, flags, out_valid=1 registered on the accepting edge (latency 1 cycle).
REQ-027 MUL: operands latched on accept; one shift-add step per cycle; out_valid asserted on edge ending the WIDTH-th BUSY cycle (latency WIDTH+1 cycles from accept edge).
REQ-028 busy = 1 exactly while state == MUL_BUSY; in_ready = 0 then.
REQ-029 result and flags SHALL hold stable while out_valid && !out_ready.
REQ-030 Same-cycle consume and accept: out_valid stays 1, new result loaded, no bubble.
REQ-031 out_valid clears on consume with no new completion in that cycle.
REQ-032 Inputs ignored when not accepted; no combinational path from in_* to result/flags.

Reset
REQ-033 rst_n low: state IDLE, out_valid=0, busy=0, result=0, N=Z=C=V=0, multiply accumulator cleared, immediately and asynchronously.
REQ-034 Reset mid-MUL SHALL abandon the operation; no result emitted afterwards.
REQ-035 in_ready = 1 on first clock edge after rst_n deasserts.

Structure
REQ-036 Opcode encodings, logic function indices and state encodings SHALL live in shared package alu_pkg.
REQ-037 Iterative multiplier SHALL be sub-module alu_mul_iter (start, operands, done, product), instantiated only when MUL_EN=1.
REQ-038 Adder and logic unit SHALL be combinational inside alu_pipe feeding the output register.

Verification (WIDTH=32)
REQ-039 ADD a=0x7FFFFFFF b=0x00000001 cin=0 -> next cycle result 0x80000000, N=1 Z=0 C=0 V=1.
REQ-040 ADD a=5 b=5 invert_b=1 cin=1 -> result 0, Z=1 C=1 V=0 N=0.
REQ-041 XOR a=0xFFFF0000 b=0x0F0F0F0F -> result 0xF0F00F0F, N=1, C=V=0.
REQ-042 MUL a=0x00010003 b=5 -> busy=1 and in_ready=0 for 32 cycles, then result 0x0005000F, out_valid=1.
REQ-043 Hold out_ready=0 3 cycles after ADD -> result/flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same cycle, back-to-back out_valid.
REQ-044 Assert rst_n=0 at cycle 10 of MUL -> all outputs 0 immediately; after release in_ready=1, no stale result appears.
